bbox_draw: RTL and testbench
============================

Name: bbox_draw

Overview:
Frame-memory writer that draws a one-pixel rectangle outline into the image buffer. The rectangle is given by the xMin/xMax/yMin/yMax coordinates produced by the bounding-box scanner. It uses the scanner's memory layout: column-major, three 16-bit channel words per pixel, addr = x*HEIGHT*3 + y*3 + c, with c = 0 for R, 1 for G, 2 for B. It sits after the scanner and annotates the same frame buffer before display or readout.

Parameters:
WIDTH, 100, image width in pixels; x is in 0..WIDTH-1
HEIGHT, 100, image height in pixels; y is in 0..HEIGHT-1

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a draw; sampled only in IDLE or DONE
xMin, xMax, yMin, yMax  in  11 each  rectangle corners, inclusive
colR, colG, colB  in  16 each  outline colour, one word per channel
addr  out  32  write word address
wrdata  out  16  write data
wren  out  1  write request
wrready  in  1  memory accepts the write this cycle; a transfer occurs when wren && wrready
done  out  1  level; high in DONE only
err  out  1  high in DONE when the last request had out-of-range coordinates

Behaviour:
- Reset values: wren=0, done=0, err=0, addr=0, wrdata=0, state=IDLE. Reset mid-draw aborts with no further writes; the write in flight is not guaranteed.
- States:
  - IDLE: start=1 registers all coordinates and colours, then goes to CHECK.
  - CHECK (one cycle):
    - xMax>=WIDTH or yMax>=HEIGHT → DONE with err=1.
    - Otherwise xMin>xMax or yMin>yMax (empty box from the scanner) → DONE with err=0 and no writes.
    - Otherwise → TOP.
  - TOP: y=yMin, x=xMin..xMax.
  - BOT: y=yMax, x=xMin..xMax. Skipped if yMax==yMin.
  - LEFT: x=xMin, y=yMin+1..yMax-1. Skipped if yMax-yMin<2.
  - RIGHT: x=xMax, y=yMin+1..yMax-1. Skipped if yMax-yMin<2 or xMax==xMin.
  - DONE: done=1. start=1 clears done and err and behaves as in IDLE.
- Write sequence:
  - Each pixel is written as c=0,1,2 in order, with wrdata = colR/colG/colB.
  - c, x and y advance only on an accepted transfer.
  - After the final accepted write, the next state is DONE, and done rises one cycle later.
- Outputs:
  - wren is high throughout the drawing states.
  - addr and wrdata are driven from registered x, y, c and state, and stay stable while wren=1 and wrready=0.
- start is ignored outside IDLE and DONE.
- Write count is 3*P, where P is the number of perimeter pixels; no pixel is written twice.
- Arithmetic:
  - Address computed at 32 bits; no overflow for WIDTH, HEIGHT ≤ 2047.
  - Coordinate compares are unsigned 11-bit.

Optional Feature:
BBOX_DRAW_FILL_EN
- Defined: adds input fill (1 bit), sampled with start. When fill=1, the FILL state replaces TOP/BOT/LEFT/RIGHT and writes every pixel with x in xMin..xMax and y in yMin..yMax. Order is column-major: y inner, x outer. fill=0 gives the outline behaviour.
- Undefined: port absent; outline only.

Decomposition:
- Shared package bbox_pkg:
  - COORD_W=11, DATA_W=16, ADDR_W=32
  - state enum typedef (IDLE, CHECK, TOP, BOT, LEFT, RIGHT, FILL, DONE)
  - channel index typedef (R=0, G=1, B=2)
- Sub-module pixel_addr_gen (parameters WIDTH, HEIGHT): combinational mapping of x, y, c to addr. Reusable by the scanner.

Test Plan:
1. WIDTH=8, HEIGHT=6; box x 2..4, y 1..3; col=(1,2,3); wrready=1 → 24 writes. First write addr=39 (2*18+1*3+0), data 1. Pixel (3,2) is never written. done high one cycle after the last write.
2. Box x=y=5 (single pixel) → exactly 3 writes at addr 105, 106, 107; done=1, err=0.
3. Box xMin=7, xMax=0 (empty) → no wren; done rises 2 cycles after start; err=0.
4. xMax=8 with WIDTH=8 → no writes; done=1, err=1. Then start with a valid box → err clears and the draw proceeds.
5. Scenario 1 with wrready held low for 5 cycles on the 4th write → addr and wrdata unchanged during the stall; total still 24 writes with no duplicates.
6. rst=1 after the 10th write → wren=0 and done=0 on the next cycle. A new start redraws the full 24 writes.

Source files
------------

// File: rtl/bbox_draw_pkg.sv
// Shared types and widths for the bounding-box drawing path.
// Used by bbox_draw, its address generator and the write-bus interface.
package bbox_pkg;

    localparam int COORD_W = 11;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 32;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DATA_W-1:0]  word_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        TOP,
        BOT,
        LEFT,
        RIGHT,
        FILL,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_t;

    // Inclusive rectangle corners as captured on start.
    typedef struct packed {
        coord_t x_min;
        coord_t x_max;
        coord_t y_min;
        coord_t y_max;
    } box_t;

    // Outline colour, one word per channel.
    typedef struct packed {
        word_t r;
        word_t g;
        word_t b;
    } color_t;

    // True in every state that presents a write to the frame buffer.
    function automatic logic is_drawing(state_t s);
        return (s == TOP) || (s == BOT) || (s == LEFT) || (s == RIGHT) || (s == FILL);
    endfunction

endpackage

// File: rtl/bbox_draw_if.sv
// Frame-buffer write port: one word per transfer, transfer when wren && wrready.
interface bbox_draw_if;
    import bbox_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
    logic              wrready;

    modport master (output addr, output wrdata, output wren, input wrready);
    modport slave  (input addr, input wrdata, input wren, output wrready);

endinterface

// File: rtl/bbox_draw_pixel_addr_gen.sv
// Column-major RGB frame-buffer address map: addr = x*HEIGHT*3 + y*3 + c.
// Purely combinational so the scanner can share the same mapping.
module pixel_addr_gen
    import bbox_pkg::*;
#(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100
) (
    input  coord_t            x,
    input  coord_t            y,
    input  chan_t             c,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(HEIGHT * 3);

    // Widen every term to 32 bits before multiplying so large frames do not wrap.
    always_comb begin
        addr     = ADDR_W'(x) * COL_STRIDE + ADDR_W'(y) * ADDR_W'(3) + ADDR_W'(c);
        in_range = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
    end

endmodule

// File: rtl/bbox_draw.sv
// Draws a one-pixel rectangle outline (or, with BBOX_DRAW_FILL_EN defined,
// optionally a filled rectangle) into the column-major RGB frame buffer.
// Each pixel is three consecutive word writes R, G, B; every counter
// advances only on an accepted transfer, so the bus may stall freely.
module bbox_draw
    import bbox_pkg::*;
#(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef BBOX_DRAW_FILL_EN
    input  logic         fill,
`endif
    input  coord_t       xMin,
    input  coord_t       xMax,
    input  coord_t       yMin,
    input  coord_t       yMax,
    input  word_t        colR,
    input  word_t        colG,
    input  word_t        colB,
    bbox_draw_if.master  wr,
    output logic         done,
    output logic         err
);

    state_t state_q, state_d;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    chan_t  c_q, c_d;
    logic   err_q, err_d;
    box_t   box_q, box_d;
    color_t col_q, col_d;
`ifdef BBOX_DRAW_FILL_EN
    logic   fill_q, fill_d;
`endif

    logic              drawing;
    logic              accept;
    logic              pixel_done;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_in_range;
    word_t             chan_word;

    pixel_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_addr (
        .x        (x_q),
        .y        (y_q),
        .c        (c_q),
        .addr     (pix_addr),
        .in_range (pix_in_range)
    );

    // Control and walk registers; reset returns to IDLE with no write pending.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= CH_R;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    // Request capture registers (box, colour, fill mode).
    // NOTE: these are deliberately not reset; they are always loaded on start
    // before CHECK reads them, and wrdata is gated to zero outside drawing.
    always_ff @(posedge clk) begin
        box_q  <= box_d;
        col_q  <= col_d;
`ifdef BBOX_DRAW_FILL_EN
        fill_q <= fill_d;
`endif
    end

    // Next-state, walk and capture logic.
    // NOTE: every variable gets a hold default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        err_d   = err_q;
        box_d   = box_q;
        col_d   = col_q;
`ifdef BBOX_DRAW_FILL_EN
        fill_d  = fill_q;
`endif

        accept     = is_drawing(state_q) && wr.wrready;
        pixel_done = accept && (c_q == CH_B);

        if (accept) begin
            c_d = (c_q == CH_B) ? CH_R : chan_t'(c_q + 2'd1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CHECK;
                    err_d   = 1'b0;
                    box_d   = '{x_min: xMin, x_max: xMax, y_min: yMin, y_max: yMax};
                    col_d   = '{r: colR, g: colG, b: colB};
`ifdef BBOX_DRAW_FILL_EN
                    fill_d  = fill;
`endif
                end
            end

            CHECK: begin
                x_d = box_q.x_min;
                y_d = box_q.y_min;
                c_d = CH_R;
                if ((int'(box_q.x_max) >= WIDTH) || (int'(box_q.y_max) >= HEIGHT)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if ((box_q.x_min > box_q.x_max) || (box_q.y_min > box_q.y_max)) begin
                    state_d = DONE;
                end else begin
`ifdef BBOX_DRAW_FILL_EN
                    state_d = fill_q ? FILL : TOP;
`else
                    state_d = TOP;
`endif
                end
            end

            TOP: begin
                if (pixel_done) begin
                    if (x_q != box_q.x_max) begin
                        x_d = x_q + coord_t'(1);
                    end else if (box_q.y_max != box_q.y_min) begin
                        state_d = BOT;
                        x_d     = box_q.x_min;
                        y_d     = box_q.y_max;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            BOT: begin
                if (pixel_done) begin
                    if (x_q != box_q.x_max) begin
                        x_d = x_q + coord_t'(1);
                    end else if ((box_q.y_max - box_q.y_min) >= coord_t'(2)) begin
                        state_d = LEFT;
                        x_d     = box_q.x_min;
                        y_d     = box_q.y_min + coord_t'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            LEFT: begin
                if (pixel_done) begin
                    if (y_q != box_q.y_max - coord_t'(1)) begin
                        y_d = y_q + coord_t'(1);
                    end else if (box_q.x_max != box_q.x_min) begin
                        state_d = RIGHT;
                        x_d     = box_q.x_max;
                        y_d     = box_q.y_min + coord_t'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            RIGHT: begin
                if (pixel_done) begin
                    if (y_q != box_q.y_max - coord_t'(1)) begin
                        y_d = y_q + coord_t'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            FILL: begin
                // y is the inner loop so consecutive pixels are consecutive addresses.
                if (pixel_done) begin
                    if (y_q != box_q.y_max) begin
                        y_d = y_q + coord_t'(1);
                    end else begin
                        y_d = box_q.y_min;
                        if (x_q != box_q.x_max) begin
                            x_d = x_q + coord_t'(1);
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Channel word selected by the registered channel index.
    always_comb begin
        case (c_q)
            CH_R:    chan_word = col_q.r;
            CH_G:    chan_word = col_q.g;
            default: chan_word = col_q.b;
        endcase
    end

    // Bus outputs derive only from registers, so they hold steady across stalls.
    always_comb begin
        drawing   = is_drawing(state_q);
        wr.wren   = drawing;
        wr.addr   = (drawing && pix_in_range) ? pix_addr : '0;
        wr.wrdata = drawing ? chan_word : '0;
        done      = (state_q == DONE);
        err       = err_q;
    end

endmodule

// File: tb/tb_bbox_draw.sv
// Scoreboard bench for bbox_draw on an 8x6 frame: stimulus pushes expected
// writes, a negedge monitor pops and compares every accepted transfer.
module tb_bbox_draw;
    import bbox_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   start;
    coord_t xMin, xMax, yMin, yMax;
    word_t  colR, colG, colB;
    logic   done, err;
`ifdef BBOX_DRAW_FILL_EN
    logic   fill;
`endif

    bbox_draw_if wr();

    bbox_draw #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef BBOX_DRAW_FILL_EN
        .fill  (fill),
`endif
        .xMin  (xMin),
        .xMax  (xMax),
        .yMin  (yMin),
        .yMax  (yMax),
        .colR  (colR),
        .colG  (colG),
        .colB  (colB),
        .wr    (wr.master),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    wr_t         sb[$];
    logic [31:0] seen[$];
    int          total = 0;
    int          bad   = 0;
    int          wr_cnt = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each accepted transfer must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst === 1'b0 && wr.wren === 1'b1 && wr.wrready === 1'b1) begin
            wr_cnt++;
            seen.push_back(wr.addr);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         wr.addr, wr.wrdata);
            end else begin
                e = sb.pop_front();
                check("wr_addr", wr.addr, e.addr);
                check("wr_data", 32'(wr.wrdata), 32'(e.data));
            end
        end
    end

    function automatic void push_px(int x, int y, word_t r, word_t g, word_t b);
        sb.push_back('{addr: 32'(x * H * 3 + y * 3 + 0), data: r});
        sb.push_back('{addr: 32'(x * H * 3 + y * 3 + 1), data: g});
        sb.push_back('{addr: 32'(x * H * 3 + y * 3 + 2), data: b});
    endfunction

    // Reference outline order: top row, bottom row, left column, right column.
    function automatic void push_outline(int x0, int x1, int y0, int y1,
                                         word_t r, word_t g, word_t b);
        for (int x = x0; x <= x1; x++) push_px(x, y0, r, g, b);
        if (y1 != y0)
            for (int x = x0; x <= x1; x++) push_px(x, y1, r, g, b);
        if (y1 - y0 >= 2) begin
            for (int y = y0 + 1; y < y1; y++) push_px(x0, y, r, g, b);
            if (x1 != x0)
                for (int y = y0 + 1; y < y1; y++) push_px(x1, y, r, g, b);
        end
    endfunction

    // Issue one start pulse; returns one cycle later with the DUT in CHECK.
    task automatic do_start(int x0, int x1, int y0, int y1, word_t r, word_t g, word_t b);
        @(posedge clk); #1;
        xMin = coord_t'(x0); xMax = coord_t'(x1);
        yMin = coord_t'(y0); yMax = coord_t'(y1);
        colR = r; colG = g; colB = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for all expected writes to be seen, then check done timing.
    task automatic drain_and_finish(string name, int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d writes pending, expected 0", name, sb.size());
            sb.delete();
        end
        check({name, "_done_before"}, 32'(done), 32'd0);
        @(negedge clk); #1;
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_wren_off"}, 32'(wr.wren), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic wait_writes(int target, int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("wait_writes_reached", 32'(wr_cnt), 32'(target));
    endtask

    function automatic int dup_count();
        int d = 0;
        for (int i = 0; i < seen.size(); i++)
            for (int j = i + 1; j < seen.size(); j++)
                if (seen[i] == seen[j]) d++;
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hits;
        rst = 1'b1; start = 1'b0; wr.wrready = 1'b1;
        xMin = '0; xMax = '0; yMin = '0; yMax = '0;
        colR = '0; colG = '0; colB = '0;
`ifdef BBOX_DRAW_FILL_EN
        fill = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wren", 32'(wr.wren), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", wr.addr, 32'd0);
        check("rst_wrdata", 32'(wr.wrdata), 32'd0);

        // 1: 3x3 outline, 8 perimeter pixels
        seen.delete(); base = wr_cnt;
        push_outline(2, 4, 1, 3, 16'd1, 16'd2, 16'd3);
        do_start(2, 4, 1, 3, 16'd1, 16'd2, 16'd3);
        drain_and_finish("t1", 200);
        check("t1_count", 32'(wr_cnt - base), 32'd24);
        check("t1_first_addr", seen[0], 32'd39);
        hits = 0;
        foreach (seen[i]) if (seen[i] >= 32'd60 && seen[i] <= 32'd62) hits++;
        check("t1_center_untouched", 32'(hits), 32'd0);
        check("t1_no_dup", 32'(dup_count()), 32'd0);

        // 2: single pixel at (5,5)
        seen.delete(); base = wr_cnt;
        sb.push_back('{addr: 32'd105, data: 16'd4});
        sb.push_back('{addr: 32'd106, data: 16'd5});
        sb.push_back('{addr: 32'd107, data: 16'd6});
        do_start(5, 5, 5, 5, 16'd4, 16'd5, 16'd6);
        drain_and_finish("t2", 50);
        check("t2_count", 32'(wr_cnt - base), 32'd3);

        // 3: empty box, done two cycles after start
        base = wr_cnt;
        do_start(7, 0, 0, 0, 16'd9, 16'd9, 16'd9);
        check("t3_done_check", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("t3_done", 32'(done), 32'd1);
        check("t3_err", 32'(err), 32'd0);
        check("t3_count", 32'(wr_cnt - base), 32'd0);

        // 4: out of range, then a valid draw clears err
        base = wr_cnt;
        do_start(0, 8, 0, 1, 16'd9, 16'd9, 16'd9);
        @(posedge clk); #1;
        check("t4_done", 32'(done), 32'd1);
        check("t4_err", 32'(err), 32'd1);
        check("t4_count", 32'(wr_cnt - base), 32'd0);
        seen.delete(); base = wr_cnt;
        push_outline(2, 4, 1, 3, 16'd7, 16'd8, 16'd9);
        do_start(2, 4, 1, 3, 16'd7, 16'd8, 16'd9);
        check("t4_err_cleared", 32'(err), 32'd0);
        check("t4_done_cleared", 32'(done), 32'd0);
        drain_and_finish("t4b", 200);
        check("t4b_count", 32'(wr_cnt - base), 32'd24);

        // 5: stall the 4th write (pixel (3,1) R -> addr 57, data 1)
        seen.delete(); base = wr_cnt;
        push_outline(2, 4, 1, 3, 16'd1, 16'd2, 16'd3);
        do_start(2, 4, 1, 3, 16'd1, 16'd2, 16'd3);
        wait_writes(base + 3, 50);
        @(posedge clk); #1;
        wr.wrready = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            check("t5_stall_addr", wr.addr, 32'd57);
            check("t5_stall_data", 32'(wr.wrdata), 32'd1);
            check("t5_stall_wren", 32'(wr.wren), 32'd1);
            @(posedge clk); #1;
        end
        wr.wrready = 1'b1;
        drain_and_finish("t5", 200);
        check("t5_count", 32'(wr_cnt - base), 32'd24);
        check("t5_no_dup", 32'(dup_count()), 32'd0);

        // 6: reset after the 10th write, then a full redraw
        base = wr_cnt;
        push_outline(2, 4, 1, 3, 16'd1, 16'd2, 16'd3);
        do_start(2, 4, 1, 3, 16'd1, 16'd2, 16'd3);
        wait_writes(base + 10, 50);
        @(posedge clk); #1;
        rst = 1'b1;
        wr.wrready = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_wren", 32'(wr.wren), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        wr.wrready = 1'b1;
        sb.delete();
        seen.delete(); base = wr_cnt;
        push_outline(2, 4, 1, 3, 16'd1, 16'd2, 16'd3);
        do_start(2, 4, 1, 3, 16'd1, 16'd2, 16'd3);
        drain_and_finish("t6", 200);
        check("t6_count", 32'(wr_cnt - base), 32'd24);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
